// File: rtl/freq_count_fsm.sv
// freq_count_fsm: gated edge counter with repeated-subtraction BCD split.
// Counts edge_in pulses over an UPDATE_PERIOD-cycle gate window, converts
// the (99-clamped) count to tens/units digits and strobes them out.
// Optional feature macro: FREQ_OVERFLOW_EN (adds the ovf_seen tracking
// register; otherwise overflow is tied to 0).
module freq_count_fsm #(
    parameter int UPDATE_PERIOD = 1200,
    parameter int COUNT_W       = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       edge_in,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       digits_valid,
    output logic       overflow
);

    localparam int CYC_W = $clog2(UPDATE_PERIOD);

    localparam logic [CYC_W-1:0]   CYC_LAST  = CYC_W'(UPDATE_PERIOD - 1);
    localparam logic [CYC_W-1:0]   CYC_ONE   = CYC_W'(1);
    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(99);
    localparam logic [COUNT_W-1:0] TEN       = COUNT_W'(10);
    localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);

    localparam logic [1:0] ST_COUNT = 2'd0;
    localparam logic [1:0] ST_TENS  = 2'd1;
    localparam logic [1:0] ST_UNITS = 2'd2;

    logic [1:0]         state_q,      state_d;
    logic [CYC_W-1:0]   cycle_cnt_q,  cycle_cnt_d;
    logic [COUNT_W-1:0] edge_count_q, edge_count_d;
    logic [3:0]         tens_acc_q,   tens_acc_d;
    logic [3:0]         tens_q,       tens_d;
    logic [3:0]         units_q,      units_d;
    logic               valid_q,      valid_d;
`ifdef FREQ_OVERFLOW_EN
    logic               ovf_seen_q,   ovf_seen_d;
    logic               overflow_q,   overflow_d;
`endif

    // Next-state logic: gate window counting, then one subtraction per cycle
    always_comb begin
        state_d      = state_q;
        cycle_cnt_d  = cycle_cnt_q;
        edge_count_d = edge_count_q;
        tens_acc_d   = tens_acc_q;
        tens_d       = tens_q;
        units_d      = units_q;
        valid_d      = 1'b0;
`ifdef FREQ_OVERFLOW_EN
        ovf_seen_d   = ovf_seen_q;
        overflow_d   = overflow_q;
`endif
        case (state_q)
            ST_COUNT: begin
                cycle_cnt_d = cycle_cnt_q + CYC_ONE;
                // Saturate at 99 so the conversion always yields valid BCD
                if (edge_in) begin
                    if (edge_count_q == MAX_COUNT) begin
`ifdef FREQ_OVERFLOW_EN
                        ovf_seen_d = 1'b1;
`endif
                    end else begin
                        edge_count_d = edge_count_q + CNT_ONE;
                    end
                end
                // The edge on the last window cycle is still counted above
                if (cycle_cnt_q == CYC_LAST) begin
                    cycle_cnt_d = '0;
                    state_d     = ST_TENS;
                end
            end
            ST_TENS: begin
                // edge_in is ignored here: dead time between windows
                if (edge_count_q >= TEN) begin
                    edge_count_d = edge_count_q - TEN;
                    tens_acc_d   = tens_acc_q + 4'd1;
                end else begin
                    state_d = ST_UNITS;
                end
            end
            ST_UNITS: begin
                tens_d       = tens_acc_q;
                units_d      = edge_count_q[3:0];
                valid_d      = 1'b1;
                edge_count_d = '0;
                tens_acc_d   = '0;
`ifdef FREQ_OVERFLOW_EN
                overflow_d   = ovf_seen_q;
                ovf_seen_d   = 1'b0;
`endif
                state_d      = ST_COUNT;
            end
            default: begin
                state_d = ST_COUNT;
            end
        endcase
    end

    // State and output registers; reset aborts any window or conversion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_COUNT;
            cycle_cnt_q  <= '0;
            edge_count_q <= '0;
            tens_acc_q   <= '0;
            tens_q       <= '0;
            units_q      <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cycle_cnt_q  <= cycle_cnt_d;
            edge_count_q <= edge_count_d;
            tens_acc_q   <= tens_acc_d;
            tens_q       <= tens_d;
            units_q      <= units_d;
            valid_q      <= valid_d;
        end
    end

`ifdef FREQ_OVERFLOW_EN
    // Saturation tracking, published alongside the digits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_seen_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ovf_seen_q <= ovf_seen_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign tens         = tens_q;
    assign units        = units_q;
    assign digits_valid = valid_q;

endmodule

// File: tb/tb_freq_count_fsm.sv
// Directed self-checking bench for freq_count_fsm with UPDATE_PERIOD=200.
// Window cycle k is the clock period in which the DUT holds cycle_cnt==k;
// edge_in driven during that period is sampled on its closing rising edge.
module tb_freq_count_fsm;

    localparam int P = 200;

    logic       clk = 1'b0;
    logic       reset;
    logic       edge_in;
    logic [3:0] tens;
    logic [3:0] units;
    logic       digits_valid;
    logic       overflow;

    int tests = 0;
    int fails = 0;
    int cyc;
    bit sched [0:511];

`ifdef FREQ_OVERFLOW_EN
    localparam int EXP_OVF_SAT = 1;
`else
    localparam int EXP_OVF_SAT = 0;
`endif

    always #5 clk = ~clk;

    freq_count_fsm #(
        .UPDATE_PERIOD(P),
        .COUNT_W      (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .edge_in     (edge_in),
        .tens        (tens),
        .units       (units),
        .digits_valid(digits_valid),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 512; i++) sched[i] = 1'b0;
    endtask

    // Runs one window from its cycle 0 (current negedge) until the strobe
    // cycle, which is also the next window's cycle 0; returns before driving it.
    task automatic run_window(input string tag, input int exp_strobe,
                              input int exp_t, input int exp_u, input int exp_o);
        int got;
        got = -1;
        cyc = 0;
        for (int k = 0; k < P + 20; k++) begin
            if (cyc > 0 && digits_valid === 1'b1) begin
                got = cyc;
                break;
            end
            edge_in = sched[cyc];
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        edge_in = 1'b0;
        $display("[TB] window %s: strobe_cycle=%0d tens=%0d units=%0d overflow=%0d",
                 tag, got, tens, units, overflow);
        check({tag, "_strobe_cycle"}, got, exp_strobe);
        check({tag, "_tens"}, {28'd0, tens}, exp_t);
        check({tag, "_units"}, {28'd0, units}, exp_u);
        check({tag, "_overflow"}, {31'd0, overflow}, exp_o);
    endtask

    initial begin
        edge_in = 1'b0;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tens", {28'd0, tens}, 0);
        check("reset_units", {28'd0, units}, 0);
        check("reset_valid", {31'd0, digits_valid}, 0);
        check("reset_overflow", {31'd0, overflow}, 0);
        reset = 1'b0;

        // 37 edges spread over the window: 200 + 3 + 2
        clear_sched();
        for (int i = 0; i < 37; i++) sched[i * 5] = 1'b1;
        run_window("e37", 205, 3, 7, 0);

        // Empty window, back to back: 200 + 0 + 2
        clear_sched();
        run_window("e0", 202, 0, 0, 0);

        // 150 edges, one per cycle: clamps to 99, 200 + 9 + 2
        clear_sched();
        for (int i = 0; i < 150; i++) sched[i] = 1'b1;
        run_window("e150", 211, 9, 9, EXP_OVF_SAT);

        // 25 then 4: no carry-over of count or overflow
        clear_sched();
        for (int i = 0; i < 25; i++) sched[10 + i * 3] = 1'b1;
        run_window("e25", 204, 2, 5, 0);
        clear_sched();
        for (int i = 0; i < 4; i++) sched[100 + i] = 1'b1;
        run_window("e4", 202, 0, 4, 0);

        // 9 mid-window + final-cycle edge; edges in TENS (200,201) and UNITS (202) dropped
        clear_sched();
        for (int i = 0; i < 9; i++) sched[50 + i] = 1'b1;
        sched[P - 1] = 1'b1;
        sched[200] = 1'b1;
        sched[201] = 1'b1;
        sched[202] = 1'b1;
        run_window("final_edge", 203, 1, 0, 0);

        // Strobe lasts one cycle, digits hold afterwards (this is next window's cycle 0)
        edge_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("strobe_one_cycle", {31'd0, digits_valid}, 0);
        check("hold_tens", {28'd0, tens}, 1);
        check("hold_units", {28'd0, units}, 0);

        // 50 edges on cycles 1..50, then advance into TENS (cycle 201)
        for (int c = 1; c <= 200; c++) begin
            edge_in = (c <= 50);
            @(posedge clk);
            @(negedge clk);
        end
        edge_in = 1'b0;
        check("pre_reset_tens", {28'd0, tens}, 1);
        check("pre_reset_valid", {31'd0, digits_valid}, 0);
        #2 reset = 1'b1;
        #1;
        $display("[TB] async reset during TENS: tens=%0d units=%0d valid=%0d overflow=%0d",
                 tens, units, digits_valid, overflow);
        check("async_reset_tens", {28'd0, tens}, 0);
        check("async_reset_units", {28'd0, units}, 0);
        check("async_reset_valid", {31'd0, digits_valid}, 0);
        check("async_reset_overflow", {31'd0, overflow}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Only post-release edges count
        clear_sched();
        for (int i = 0; i < 4; i++) sched[10 + i] = 1'b1;
        run_window("after_reset", 202, 0, 4, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
